// File: rtl/mem_responder_if.sv
// mem_responder_if: core-side memory transaction bus.
// master = core, slave = memory responder.
`timescale 1ns/1ps
interface mem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    output size_i, unsigned_i,
    input  ready_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    input  size_i, unsigned_i,
    output ready_o, rdata_o, err_o, busy_o
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: unified I/D word memory answering one core access
// per LATENCY+2 cycles. Define MEM_ALIGN_CHECK_EN to fault misalignment.
`timescale 1ns/1ps
module mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  localparam logic [3:0] LAST =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        range_err;
  logic        size_err;
  logic        align_err;
  logic        err;
  logic        ready;
  logic        wr_en;
  logic [31:0] word;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] wr_word;

  // state and wait counter; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // next state: IDLE -> (WAIT) -> RESP -> IDLE
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nx = 4'd0;
        if (bus.req_i)
          state_nx = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == LAST) begin
          state_nx = RESP;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // capture the request so later input changes cannot leak in
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && bus.req_i) begin
      we_q    <= bus.we_i;
      addr_q  <= bus.addr_i;
      wdata_q <= bus.wdata_i;
      size_q  <= bus.size_i;
      uns_q   <= bus.unsigned_i;
    end
  end

  assign off       = addr_q - BASE_ADDR;
  assign idx       = off[AW+1:2];
  assign range_err = (addr_q < BASE_ADDR) ||
                     ({1'b0, off} >= SPAN);
  assign size_err  = &size_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err =
    (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
    (size_q == 2'b01 && addr_q[0]);
`else
  assign align_err = 1'b0;
`endif

  assign err   = range_err | size_err | align_err;
  assign ready = (state == RESP);
  assign wr_en = ready && we_q && !err;
  assign word  = mem[idx];

  // lane shift and byte mask for the addressed access size
  always_comb begin
    sh   = 5'd0;
    mask = '1;
    case (size_q)
      2'b00: begin
        sh   = {addr_q[1:0], 3'b000};
        mask = 32'h0000_00FF << sh;
      end
      2'b01: begin
        sh   = {addr_q[1], 4'b0000};
        mask = 32'h0000_FFFF << sh;
      end
      default: begin
        sh   = 5'd0;
        mask = '1;
      end
    endcase
  end

  assign shifted = word >> sh;
  assign wr_word = (word & ~mask) |
                   ((wdata_q << sh) & mask);

  // load extension of the selected lane
  always_comb begin
    load_val = '0;
    case (size_q)
      2'b00: load_val = {{24{shifted[7] & ~uns_q}},
                         shifted[7:0]};
      2'b01: load_val = {{16{shifted[15] & ~uns_q}},
                         shifted[15:0]};
      2'b10: load_val = word;
      default: load_val = '0;
    endcase
  end

  // stores land at the end of the response cycle
  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[idx] <= wr_word;
  end

  assign bus.ready_o = ready;
  assign bus.busy_o  = (state != IDLE);
  assign bus.err_o   = ready && err;
  assign bus.rdata_o = (ready && !err && !we_q) ?
                       load_val : 32'd0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at
// LATENCY 0, 1 and 3 (one instance each).
`timescale 1ns/1ps
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SX = 2'b11;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  logic [2:0]  req_v = '0;
  logic        we = 1'b0;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = 2'b10;

  int tests_run = 0;
  int fails = 0;

  mem_responder_if b0 ();
  mem_responder_if b1 ();
  mem_responder_if b3 ();

  assign b0.req_i = req_v[0];
  assign b1.req_i = req_v[1];
  assign b3.req_i = req_v[2];
  assign b0.we_i = we;
  assign b1.we_i = we;
  assign b3.we_i = we;
  assign b0.addr_i = addr;
  assign b1.addr_i = addr;
  assign b3.addr_i = addr;
  assign b0.wdata_i = wdata;
  assign b1.wdata_i = wdata;
  assign b3.wdata_i = wdata;
  assign b0.size_i = size;
  assign b1.size_i = size;
  assign b3.size_i = size;
  assign b0.unsigned_i = uns;
  assign b1.unsigned_i = uns;
  assign b3.unsigned_i = uns;

  mem_responder #(.DEPTH(1024), .LATENCY(0),
    .BASE_ADDR(32'h0040_0000))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  mem_responder #(.DEPTH(1024), .LATENCY(1),
    .BASE_ADDR(32'h0040_0000))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_responder #(.DEPTH(1024), .LATENCY(3),
    .BASE_ADDR(32'h0040_0000))
    u3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic peek(input int k, output logic r,
    output logic [31:0] d, output logic e, output logic b);
    case (k)
      0: begin
        r = b0.ready_o; d = b0.rdata_o;
        e = b0.err_o;   b = b0.busy_o;
      end
      1: begin
        r = b1.ready_o; d = b1.rdata_o;
        e = b1.err_o;   b = b1.busy_o;
      end
      default: begin
        r = b3.ready_o; d = b3.rdata_o;
        e = b3.err_o;   b = b3.busy_o;
      end
    endcase
  endtask

  // one transaction; starts and ends at a negedge, inputs are
  // scrambled right after acceptance, timing is measured
  task automatic xact(input int k, input logic w,
    input logic [31:0] a, input logic [31:0] d,
    input logic [1:0] sz, input logic u,
    output logic [31:0] rd, output logic e,
    output int lat, output bit clean);
    logic r, ee, bb;
    logic [31:0] dd;
    lat = -1; rd = '0; e = 1'b0; clean = 1'b1;
    we = w; addr = a; wdata = d; size = sz; uns = u;
    req_v[k] = 1'b1;
    @(posedge clk); #1;
    req_v[k] = 1'b0;
    we = ~w; addr = a ^ 32'h0000_0004;
    wdata = ~d; size = ~sz; uns = ~u;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      peek(k, r, dd, ee, bb);
      if (r === 1'b1) begin
        if (lat < 0) begin
          lat = n; rd = dd; e = ee;
        end else clean = 1'b0;
      end else if (dd !== 32'd0 || ee !== 1'b0)
        clean = 1'b0;
      if (r === 1'b1 || lat < 0) begin
        if (bb !== 1'b1) clean = 1'b0;
      end else if (bb !== 1'b0) clean = 1'b0;
    end
  endtask

  task automatic test_reset;
    logic r, e, b;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      peek(k, r, d, e, b);
      tests_run++;
      if ({r, e, b, d} !== 35'd0) begin
        fails++;
        $display("FAIL reset[%0d] rdy=%b err=%b busy=%b rdata=%h exp all 0",
          k, r, e, b, d);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_load_word;
    vec_t t [4] = '{
      '{1'b1, 32'h0040_0000, 32'h8765_4321, SW, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0040_0000, 32'h0, SW, 1'b0, 32'h8765_4321, 1'b0},
      '{1'b1, 32'h0040_0004, 32'h1122_3344, SW, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0040_0004, 32'h0, SW, 1'b0, 32'h1122_3344, 1'b0}
    };
    logic [31:0] rd; logic e; int lat; bit cl;
    foreach (t[i]) begin
      xact(1, t[i].w, t[i].a, t[i].d, t[i].sz, t[i].u,
        rd, e, lat, cl);
      tests_run++;
      if ({lat[7:0], cl, e, rd} !==
          {8'd1, 1'b1, t[i].ee, t[i].er}) begin
        fails++;
        $display("FAIL load_word[%0d] lat=%0d clean=%b err=%b rdata=%h exp lat=1 clean=1 err=%b rdata=%h",
          i, lat, cl, e, rd, t[i].ee, t[i].er);
      end
    end
  endtask

  task automatic test_lanes;
    vec_t t [12] = '{
      '{1'b1, 32'h0040_0005, 32'h0000_00AB, SB, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0040_0005, 32'h0, SB, 1'b0, 32'hFFFF_FFAB, 1'b0},
      '{1'b0, 32'h0040_0005, 32'h0, SB, 1'b1, 32'h0000_00AB, 1'b0},
      '{1'b0, 32'h0040_0004, 32'h0, SW, 1'b0, 32'h1122_AB44, 1'b0},
      '{1'b1, 32'h0040_0006, 32'h0000_BEEF, SH, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0040_0006, 32'h0, SH, 1'b0, 32'hFFFF_BEEF, 1'b0},
      '{1'b0, 32'h0040_0004, 32'h0, SH, 1'b1, 32'h0000_AB44, 1'b0},
      '{1'b0, 32'h0040_0004, 32'h0, SB, 1'b0, 32'h0000_0044, 1'b0},
      '{1'b0, 32'h0040_0007, 32'h0, SB, 1'b1, 32'h0000_00BE, 1'b0},
      '{1'b0, 32'h0040_0004, 32'h0, SW, 1'b0, 32'hBEEF_AB44, 1'b0},
      '{1'b1, 32'h0040_0004, 32'h1234_5699, SB, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h0040_0004, 32'h0, SW, 1'b0, 32'hBEEF_AB99, 1'b0}
    };
    logic [31:0] rd; logic e; int lat; bit cl;
    foreach (t[i]) begin
      xact(1, t[i].w, t[i].a, t[i].d, t[i].sz, t[i].u,
        rd, e, lat, cl);
      tests_run++;
      if ({lat[7:0], cl, e, rd} !==
          {8'd1, 1'b1, t[i].ee, t[i].er}) begin
        fails++;
        $display("FAIL lanes[%0d] lat=%0d clean=%b err=%b rdata=%h exp lat=1 clean=1 err=%b rdata=%h",
          i, lat, cl, e, rd, t[i].ee, t[i].er);
      end
    end
  endtask

  task automatic test_errors;
    vec_t t [9] = '{
      '{1'b0, 32'h0040_1000, 32'h0, SW, 1'b0, 32'h0, 1'b1},
      '{1'b0, 32'h0040_0000, 32'h0, SX, 1'b0, 32'h0, 1'b1},
      '{1'b1, 32'h0040_0000, 32'h0, SX, 1'b0, 32'h0, 1'b1},
      '{1'b1, 32'h0040_1000, 32'hDEAD_BEEF, SW, 1'b0, 32'h0, 1'b1},
      '{1'b0, 32'h0040_0000, 32'h0, SW, 1'b0, 32'h8765_4321, 1'b0},
      '{1'b1, 32'h0040_0FFC, 32'h5A5A_5A5A, SW, 1'b0, 32'h0, 1'b0},
      '{1'b0, 32'h003F_FFFC, 32'h0, SW, 1'b0, 32'h0, 1'b1},
      '{1'b1, 32'h003F_FFFC, 32'hCAFE_F00D, SW, 1'b0, 32'h0, 1'b1},
      '{1'b0, 32'h0040_0FFC, 32'h0, SW, 1'b0, 32'h5A5A_5A5A, 1'b0}
    };
    logic [31:0] rd; logic e; int lat; bit cl;
    foreach (t[i]) begin
      xact(1, t[i].w, t[i].a, t[i].d, t[i].sz, t[i].u,
        rd, e, lat, cl);
      tests_run++;
      if ({lat[7:0], cl, e, rd} !==
          {8'd1, 1'b1, t[i].ee, t[i].er}) begin
        fails++;
        $display("FAIL errors[%0d] lat=%0d clean=%b err=%b rdata=%h exp lat=1 clean=1 err=%b rdata=%h",
          i, lat, cl, e, rd, t[i].ee, t[i].er);
      end
    end
  endtask

  task automatic test_misalign;
    vec_t t [5] = '{
      '{1'b0, 32'h0040_0002, 32'h0, SW, 1'b0,
        ALIGN ? 32'h0 : 32'h8765_4321, ALIGN},
      '{1'b0, 32'h0040_0005, 32'h0, SH, 1'b0,
        ALIGN ? 32'h0 : 32'hFFFF_AB99, ALIGN},
      '{1'b0, 32'h0040_0003, 32'h0, SB, 1'b0,
        32'hFFFF_FF87, 1'b0},
      '{1'b1, 32'h0040_0001, 32'h0F0F_0F0F, SW, 1'b0,
        32'h0, ALIGN},
      '{1'b0, 32'h0040_0000, 32'h0, SW, 1'b0,
        ALIGN ? 32'h8765_4321 : 32'h0F0F_0F0F, 1'b0}
    };
    logic [31:0] rd; logic e; int lat; bit cl;
    foreach (t[i]) begin
      xact(1, t[i].w, t[i].a, t[i].d, t[i].sz, t[i].u,
        rd, e, lat, cl);
      tests_run++;
      if ({lat[7:0], cl, e, rd} !==
          {8'd1, 1'b1, t[i].ee, t[i].er}) begin
        fails++;
        $display("FAIL misalign[%0d] lat=%0d clean=%b err=%b rdata=%h exp lat=1 clean=1 err=%b rdata=%h",
          i, lat, cl, e, rd, t[i].ee, t[i].er);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, d; logic e, r, b; int lat; bit cl;
    int pulses;
    xact(2, 1'b1, 32'h0040_0010, 32'h0A0A_0A0A, SW, 1'b0,
      rd, e, lat, cl);
    tests_run++;
    if ({lat[7:0], cl, e} !== {8'd3, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL lat3_store lat=%0d clean=%b err=%b exp lat=3 clean=1 err=0",
        lat, cl, e);
    end
    // cycle 0: store accepted
    we = 1'b1; addr = 32'h0040_0010;
    wdata = 32'h5555_5555; size = SW; uns = 1'b0;
    req_v[2] = 1'b1;
    @(posedge clk); #1;
    req_v[2] = 1'b0;
    @(negedge clk);
    peek(2, r, d, e, b);
    tests_run++;
    if ({r, b} !== 2'b01) begin
      fails++;
      $display("FAIL abort_wait rdy=%b busy=%b exp rdy=0 busy=1",
        r, b);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    peek(2, r, d, e, b);
    tests_run++;
    if ({r, b, e, d} !== 35'd0) begin
      fails++;
      $display("FAIL abort_reset rdy=%b busy=%b err=%b rdata=%h exp all 0",
        r, b, e, d);
    end
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      peek(2, r, d, e, b);
      if (r !== 1'b0) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL abort_no_pulse pulses=%0d exp 0", pulses);
    end
    xact(2, 1'b0, 32'h0040_0010, 32'h0, SW, 1'b0,
      rd, e, lat, cl);
    tests_run++;
    if ({lat[7:0], cl, e, rd} !==
        {8'd3, 1'b1, 1'b0, 32'h0A0A_0A0A}) begin
      fails++;
      $display("FAIL abort_old_value lat=%0d clean=%b err=%b rdata=%h exp lat=3 clean=1 err=0 rdata=0a0a0a0a",
        lat, cl, e, rd);
    end
    // reset wins over a same-cycle request
    we = 1'b0; addr = 32'h0040_0010; size = SW;
    req_v[0] = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    req_v[0] = 1'b0; rst = 1'b0;
    @(negedge clk);
    peek(0, r, d, e, b);
    tests_run++;
    if ({r, b} !== 2'b00) begin
      fails++;
      $display("FAIL rst_priority rdy=%b busy=%b exp 0 0", r, b);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] jaddr [6] = '{
      32'h0040_0024, 32'h0040_0024, 32'h0040_0020,
      32'h0040_0020, 32'h0040_0024, 32'h0040_0024};
    logic [33:0] exp_v [6] = '{
      {1'b1, 1'b1, 32'h1111_1111}, {1'b0, 1'b0, 32'h0},
      {1'b1, 1'b1, 32'h2222_2222}, {1'b0, 1'b0, 32'h0},
      {1'b1, 1'b1, 32'h1111_1111}, {1'b0, 1'b0, 32'h0}};
    logic [31:0] rd, d; logic e, r, b; int lat; bit cl;
    xact(0, 1'b1, 32'h0040_0020, 32'h1111_1111, SW, 1'b0,
      rd, e, lat, cl);
    tests_run++;
    if ({lat[7:0], cl, e} !== {8'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL lat0_store lat=%0d clean=%b err=%b exp lat=0 clean=1 err=0",
        lat, cl, e);
    end
    xact(0, 1'b1, 32'h0040_0024, 32'h2222_2222, SW, 1'b0,
      rd, e, lat, cl);
    we = 1'b0; size = SW; uns = 1'b0;
    addr = 32'h0040_0020;
    req_v[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      addr = jaddr[c];
      @(negedge clk);
      peek(0, r, d, e, b);
      if (c == 5) req_v[0] = 1'b0;
      tests_run++;
      if ({r, b, d} !== exp_v[c]) begin
        fails++;
        $display("FAIL b2b_cycle%0d rdy=%b busy=%b rdata=%h exp rdy=%b busy=%b rdata=%h",
          c + 1, r, b, d, exp_v[c][33], exp_v[c][32],
          exp_v[c][31:0]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_lanes;
    test_errors;
    test_misalign;
    test_reset_abort;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed",
      tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, number of 32-bit words in the unified instruction/data memory.
REQ-002 The block SHALL have parameter LATENCY, default 1, wait cycles inserted before each response, legal range 0..15.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0040_0000, byte address of word 0.
REQ-004 clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_i  input  1  core transaction request (FETCH, MEM_READ or MEM_WRITE phases).
REQ-007 we_i  input  1  1 = store, 0 = load or fetch.
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  store data, right-aligned.
REQ-010 size_i  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 unsigned_i  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-012 ready_o  output  1  one-cycle completion pulse; the core leaves its STALL/wait state on it.
REQ-013 rdata_o  output  32  load data, extended; valid only while ready_o=1.
REQ-014 err_o  output  1  access fault, valid only while ready_o=1.
REQ-015 busy_o  output  1  high while a transaction is captured and not yet completed.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
- IDLE & req_i -> WAIT (LATENCY>0) or RESP (LATENCY=0).
- WAIT -> RESP when the wait counter reaches LATENCY-1.
- RESP -> IDLE unconditionally.
REQ-017 On acceptance the block SHALL latch we_i, addr_i, wdata_i, size_i and unsigned_i; later input changes SHALL NOT affect the transaction.
REQ-018 With acceptance at cycle T, ready_o SHALL be high in cycle T+1+LATENCY and only that cycle.
REQ-019 req_i SHALL be ignored outside IDLE; a request is accepted in the IDLE cycle after RESP at the earliest (back-to-back throughput of one transaction per LATENCY+2 cycles).
REQ-020 busy_o SHALL be high in WAIT and RESP and low in IDLE.
REQ-021 Word index SHALL be (addr - BASE_ADDR) >> 2; out of range if addr < BASE_ADDR or addr - BASE_ADDR >= DEPTH*4.
REQ-022 Loads SHALL select the lane by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend per unsigned_i.
REQ-023 Stores SHALL write only the addressed byte lanes, in the RESP cycle, only when err_o=0.
REQ-024 Stores SHALL return rdata_o = 0.
REQ-025 err_o=1 for out-of-range, size_i=11, or (see Configuration) misalignment.
- With err_o=1: no memory write, rdata_o = 0, ready_o still pulses at the normal time.
REQ-026 rdata_o and err_o SHALL be 0 in every cycle where ready_o=0.

Reset
REQ-027 rst SHALL force IDLE, clear the wait counter, and set ready_o=0, rdata_o=0, err_o=0, busy_o=0 on the next edge.
REQ-028 rst asserted in WAIT or RESP SHALL abort the transaction; a pending store SHALL NOT be written and no ready_o pulse SHALL follow.
REQ-029 rst SHALL NOT clear memory contents.
REQ-030 rst has priority over req_i in the same cycle.

Configuration
REQ-031 Macro MEM_ALIGN_CHECK_EN defined: word access with addr[1:0]!=0, or half access with addr[0]!=0, SHALL set err_o=1.
REQ-032 Macro MEM_ALIGN_CHECK_EN undefined: misalignment SHALL NOT fault.
- Word accesses ignore addr[1:0].
- Half accesses ignore addr[0].
- err_o covers only out-of-range and size_i=11.

Verification
REQ-033 LATENCY=1: load word at 0x0040_0000 (init 0x8765_4321), req_i at cycle 0 -> ready_o=1 only in cycle 2, rdata_o=0x8765_4321, err_o=0.
REQ-034 Store byte 0xAB at 0x0040_0005, then signed byte load from 0x0040_0005 -> 0xFFFF_FFAB; unsigned -> 0x0000_00AB; word load at 0x0040_0004 shows only byte 1 changed.
REQ-035 Load at 0x0040_1000 with DEPTH=1024, and a size_i=11 access -> err_o=1 with ready_o, rdata_o=0; a store at 0x0040_1000 leaves memory unchanged.
REQ-036 Word load at 0x0040_0002: with MEM_ALIGN_CHECK_EN -> err_o=1; without -> err_o=0, rdata_o = word at 0x0040_0000.
REQ-037 Store accepted at cycle 0, LATENCY=3, rst high in cycle 2 -> no ready_o pulse, busy_o=0 after the reset edge, later load of that address returns the old value.
REQ-038 LATENCY=0, req_i held high continuously -> ready_o pulses in cycles 1, 3, 5; changing addr_i during WAIT/RESP does not alter the returned data.
